riscv_hazard_ctrl: RTL and testbench

RISCV_HAZARD_CTRL -- requirements
Module: riscv_hazard_ctrl

---
 rtl/riscv_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_riscv_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_hazard_ctrl.sv
// riscv_hazard_ctrl: pipeline hazard controller for a 5-stage RISC-V core.
// Keeps a three-entry scoreboard (EX, MEM, WB) of in-flight destination
// registers. It raises a bubble on a read-after-write dependency and a
// two-cycle flush on a taken branch.
// Build option: define RISCV_FORWARD_EN for a core with full EX/MEM
// forwarding. In that build only load-use stalls remain. Without it, EX and
// MEM producers both stall the consumer.
module riscv_hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic [4:0]  id_rd,
   input  logic        id_we,
   input  logic        id_is_load,
   input  logic        branch_taken,
   output logic        bubble,
   output logic        id_kill,
   output logic        flush,
   output logic [1:0]  state,
   output logic [15:0] stall_count
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

`ifdef RISCV_FORWARD_EN
   // Forwarding covers every ALU result, so only a load still in EX is a hazard.
   localparam logic EX_LOAD_ONLY = 1'b1;
   localparam logic CHECK_MEM    = 1'b0;
`else
   localparam logic EX_LOAD_ONLY = 1'b0;
   localparam logic CHECK_MEM    = 1'b1;
`endif
   // The register file writes before it reads, so a WB producer is never a hazard.
   localparam logic CHECK_WB     = 1'b0;

   state_t      state_q, state_d;
   logic        ex_vld_q, mem_vld_q, wb_vld_q, ex_vld_d;
   logic [4:0]  ex_rd_q, mem_rd_q, wb_rd_q;
   logic        ex_ld_q, mem_ld_q, wb_ld_q;
   logic [15:0] stall_count_q, stall_count_d;
   logic        hit_ex, hit_mem, hit_wb;
   logic        hazard, issue;

   // Dependency of the ID sources on one scoreboard entry. x0 never matches.
   function automatic logic entry_hit(input logic       vld,
                                      input logic [4:0] rd,
                                      input logic       ld,
                                      input logic       need_load,
                                      input logic [4:0] rs1,
                                      input logic       u1,
                                      input logic [4:0] rs2,
                                      input logic       u2);
      logic dep;
      dep = (u1 & (rs1 == rd)) | (u2 & (rs2 == rd));
      return vld & (rd != 5'd0) & dep & (ld | ~need_load);
   endfunction

   // The stall counter sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Hazard detection and zero-latency control outputs; all forced low in reset.
   always_comb begin
      hit_ex  = entry_hit(ex_vld_q, ex_rd_q, ex_ld_q, EX_LOAD_ONLY,
                          id_rs1, id_rs1_used, id_rs2, id_rs2_used);
      hit_mem = CHECK_MEM & entry_hit(mem_vld_q, mem_rd_q, mem_ld_q, 1'b0,
                                      id_rs1, id_rs1_used, id_rs2, id_rs2_used);
      hit_wb  = CHECK_WB & entry_hit(wb_vld_q, wb_rd_q, wb_ld_q, 1'b0,
                                     id_rs1, id_rs1_used, id_rs2, id_rs2_used);
      hazard  = 1'b0;
      flush   = 1'b0;
      bubble  = 1'b0;
      id_kill = 1'b0;
      if (!rst) begin
         // ID content is stale while flushing, so its hazards are meaningless.
         hazard  = id_valid & (hit_ex | hit_mem | hit_wb) & (state_q != ST_FLUSH);
         flush   = branch_taken | (state_q == ST_FLUSH);
         bubble  = hazard & ~flush;
         id_kill = flush | bubble;
      end
   end

   // Next-state, issue and counter update; branch wins over stall.
   always_comb begin
      state_d = ST_RUN;
      if (branch_taken) begin
         state_d = ST_FLUSH;
      end else if (bubble) begin
         state_d = ST_STALL;
      end
      issue         = id_valid & ~bubble & ~flush;
      ex_vld_d      = issue & id_we & (id_rd != 5'd0);
      stall_count_d = bubble ? sat_inc(stall_count_q) : stall_count_q;
   end

   // Control state: FSM, scoreboard valid bits and stall counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_RUN;
         ex_vld_q      <= 1'b0;
         mem_vld_q     <= 1'b0;
         wb_vld_q      <= 1'b0;
         stall_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         ex_vld_q      <= ex_vld_d;
         mem_vld_q     <= ex_vld_q;
         wb_vld_q      <= mem_vld_q;
         stall_count_q <= stall_count_d;
      end
   end

   // Scoreboard payload advances every cycle; the valid bits qualify it.
   always_ff @(posedge clk) begin
      ex_rd_q  <= id_rd;
      ex_ld_q  <= id_is_load;
      mem_rd_q <= ex_rd_q;
      mem_ld_q <= ex_ld_q;
      wb_rd_q  <= mem_rd_q;
      wb_ld_q  <= mem_ld_q;
   end

   assign state       = state_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Testbench for riscv_hazard_ctrl. It uses directed scenarios plus a
// randomized phase. All of them are checked against a reference model that
// tracks issued instructions by issue cycle.
`timescale 1ns/1ps
module tb_riscv_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst, id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load, branch_taken;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        bubble, id_kill, flush;
   logic [1:0]  state;
   logic [15:0] stall_count;

   always #5 clk = ~clk;

   riscv_hazard_ctrl dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
      .branch_taken(branch_taken),
      .bubble(bubble), .id_kill(id_kill), .flush(flush),
      .state(state), .stall_count(stall_count)
   );

`ifdef RISCV_FORWARD_EN
   localparam int EXP_B2B = 0;
   localparam int EXP_LU  = 1;
`else
   localparam int EXP_B2B = 2;
   localparam int EXP_LU  = 2;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Stimulus shadows, applied on the falling edge by step().
   logic       d_rst = 1'b1, d_valid = 1'b0, d_u1 = 1'b0, d_u2 = 1'b0;
   logic       d_we = 1'b0, d_ld = 1'b0, d_br = 1'b0;
   logic [4:0] d_rs1 = 5'd0, d_rs2 = 5'd0, d_rd = 5'd0;

   // Reference model: in-flight writers with the cycle they left ID.
   typedef struct {
      int         cyc;
      logic [4:0] rd;
      logic       ld;
   } rec_t;
   rec_t inflight[$];
   int   cyc        = 0;
   bit   m_prev_br  = 1'b0;
   bit   m_prev_bub = 1'b0;
   int   m_cnt      = 0;
   bit   m_bubble, m_flush;
   bit   known      = 1'b0;
   bit   obs_bub, obs_flush;
   logic [1:0] obs_state;

   task automatic step();
      bit haz;
      int age;
      int exp_state;
      @(negedge clk);
      rst = d_rst; id_valid = d_valid; id_rs1 = d_rs1; id_rs2 = d_rs2;
      id_rs1_used = d_u1; id_rs2_used = d_u2; id_rd = d_rd; id_we = d_we;
      id_is_load = d_ld; branch_taken = d_br;
      #1;
      cyc++;
      haz = 1'b0;
      foreach (inflight[i]) begin
         age = cyc - inflight[i].cyc;  // 1 = EX, 2 = MEM, 3 = WB
`ifdef RISCV_FORWARD_EN
         if (age == 1 && inflight[i].ld)
`else
         if (age == 1 || age == 2)
`endif
            if ((d_u1 && d_rs1 == inflight[i].rd) || (d_u2 && d_rs2 == inflight[i].rd))
               haz = 1'b1;
      end
      m_flush   = !d_rst && (d_br || m_prev_br);
      m_bubble  = !d_rst && d_valid && haz && !m_flush;
      exp_state = m_prev_br ? 2 : (m_prev_bub ? 1 : 0);
      chk("flush", flush, m_flush);
      chk("bubble", bubble, m_bubble);
      chk("id_kill", id_kill, m_flush || m_bubble);
      if (known) begin
         chk("state", state, exp_state);
         chk("stall_count", stall_count, m_cnt);
      end
      obs_bub = bubble; obs_flush = flush; obs_state = state;
      // Effects of the coming rising edge.
      if (d_rst) begin
         inflight.delete();
         m_prev_br = 1'b0; m_prev_bub = 1'b0; m_cnt = 0; known = 1'b1;
      end else begin
         if (d_valid && !m_bubble && !m_flush && d_we && d_rd != 5'd0)
            inflight.push_back('{cyc, d_rd, d_ld});
         m_prev_br  = d_br;
         m_prev_bub = m_bubble;
         if (m_bubble && m_cnt < 65535) m_cnt++;
      end
      while (inflight.size() > 0 && cyc - inflight[0].cyc >= 3) void'(inflight.pop_front());
   endtask

   task automatic set_idle();
      d_rst = 1'b0; d_valid = 1'b0; d_u1 = 1'b0; d_u2 = 1'b0;
      d_we = 1'b0; d_ld = 1'b0; d_br = 1'b0;
      d_rs1 = 5'd0; d_rs2 = 5'd0; d_rd = 5'd0;
   endtask

   task automatic set_instr(input logic [4:0] rd, input logic we, input logic ld,
                            input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2);
      d_valid = 1'b1; d_rd = rd; d_we = we; d_ld = ld;
      d_rs1 = rs1; d_u1 = u1; d_rs2 = rs2; d_u2 = u2;
   endtask

   // Hold the ID instruction until it issues; count the DUT's bubble cycles.
   task automatic run_until_issued(output int nb);
      nb = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (obs_bub) nb++;
         if (!m_bubble) break;
      end
   endtask

   task automatic do_reset();
      set_idle(); d_rst = 1'b1; step(); d_rst = 1'b0;
   endtask

   initial begin
      int nb, nf;
      set_idle();
      // Reset held two cycles with a branch pending.
      d_rst = 1'b1; d_br = 1'b1;
      set_instr(5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1);
      step(); step();
      chk("rst_bubble", obs_bub, 1'b0);
      chk("rst_state", obs_state, 2'd0);
      chk("rst_count", stall_count, 16'd0);
      set_idle();
      for (int k = 0; k < 3; k++) step();

      // addi x5 ; add x6,x5,x5
      set_instr(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); run_until_issued(nb);
      set_instr(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1); run_until_issued(nb);
      set_idle(); step();
      chk("b2b_bubbles", nb, EXP_B2B);
      chk("b2b_count", stall_count, EXP_B2B);

      // lw x7 ; add x8,x7,x0
      do_reset();
      set_instr(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); run_until_issued(nb);
      set_instr(5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b1); run_until_issued(nb);
      set_idle(); step();
      chk("lu_bubbles", nb, EXP_LU);
      chk("lu_count", stall_count, EXP_LU);

      // lw x0 ; add x8,x0,x0 never stalls
      do_reset();
      set_instr(5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); run_until_issued(nb);
      set_instr(5'd8, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1); run_until_issued(nb);
      chk("x0_bubbles", nb, 0);

      // Branch pulse: two flush cycles, one FLUSH state cycle, nothing issued.
      set_idle(); step(); step(); step();
      nf = 0;
      set_instr(5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      d_br = 1'b1; step(); if (obs_flush) nf++;
      d_br = 1'b0; step(); if (obs_flush) nf++;
      chk("br_state", obs_state, 2'd2);
      set_instr(5'd10, 1'b1, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1); step();
      if (obs_flush) nf++;
      chk("br_flush_cycles", nf, 2);
      chk("br_no_issue", obs_bub, 1'b0);

      // Hazard and branch in the same cycle.
      set_idle(); step();
      set_instr(5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step();
      set_instr(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0); d_br = 1'b1; step();
      chk("sim_bubble", obs_bub, 1'b0);
      chk("sim_flush", obs_flush, 1'b1);
      set_idle(); step();
      chk("sim_state", obs_state, 2'd2);

      // Randomized phase.
      for (int k = 0; k < 3000; k++) begin
         d_rst   = ($urandom_range(0, 63) == 0);
         d_valid = ($urandom_range(0, 3) != 0);
         d_rs1   = 5'($urandom_range(0, 3));
         d_rs2   = 5'($urandom_range(0, 3));
         d_rd    = 5'($urandom_range(0, 3));
         d_u1    = 1'($urandom_range(0, 1));
         d_u2    = 1'($urandom_range(0, 1));
         d_we    = 1'($urandom_range(0, 1));
         d_ld    = 1'($urandom_range(0, 1));
         d_br    = ($urandom_range(0, 9) == 0);
         step();
      end

      // Saturation: start the counter at 65534, then add three stalls.
      set_idle(); step(); step(); step();
      force dut.stall_count_q = 16'd65534;
      m_cnt = 65534;
      step();
      release dut.stall_count_q;
      chk("sat_preload", stall_count, 16'd65534);
      for (int r = 0; r < 3; r++) begin
         set_instr(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); run_until_issued(nb);
         set_instr(5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0); run_until_issued(nb);
         set_idle(); step(); step();
      end
      chk("sat_count", stall_count, 16'hFFFF);
      step();
      chk("sat_hold", stall_count, 16'hFFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
